fifo_stream_drain: RTL and testbench

//  Read-side adapter placed directly downstream of the synchronous FIFO.

---
 rtl/fifo_stream_drain_if.sv | 25 ++
 rtl/fifo_stream_drain.sv | 111 +++++++++++
 tb/tb_fifo_stream_drain.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_drain_if.sv
// Bundle between the FIFO read port, the drain adapter and the downstream stream consumer.
// slave = adapter side, master = FIFO/consumer side.
interface fifo_stream_drain_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [31:0]      beat_cnt;

    modport slave (
        input  en, fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, beat_cnt
    );

    modport master (
        output en, fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, beat_cnt
    );
endinterface

// File: rtl/fifo_stream_drain.sv
// Read-side adapter for a synchronous FIFO: hides the 1-cycle read latency behind a 3-entry skid buffer.
// Define FIFO_DRAIN_LAST_EN to build the PKT_LEN-beat m_last framing counter.
module fifo_stream_drain #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 16
) (
    input logic                clk,
    input logic                rst_n,
    fifo_stream_drain_if.slave bus
);

    generate
        if (PKT_LEN < 1) begin : g_pkt_len_invalid
            $error("fifo_stream_drain: PKT_LEN must be >= 1");
        end
    endgenerate

    logic             rst_ok_q, rst_ok_d;
    logic [1:0]       occ_q, occ_d;
    logic             pend_q, pend_d;
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [WIDTH-1:0] ent_q [0:2];
    logic [WIDTH-1:0] ent_d [0:2];
    logic [31:0]      beat_cnt_q, beat_cnt_d;

    logic rd_en, push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reads are issued only from registered occupancy so m_ready never reaches fifo_rd_en;
    // rst_ok_q keeps the strobe low until the first edge after reset release.
    assign rd_en = rst_ok_q & bus.en & ~bus.fifo_empty &
                   (({1'b0, occ_q} + {2'b00, pend_q}) < 3'd3);
    assign push  = pend_q;
    assign pop   = (occ_q != 2'd0) & bus.m_ready;

    always_comb begin
        rst_ok_d   = 1'b1;
        pend_d     = rd_en;
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        ent_d      = ent_q;
        beat_cnt_d = beat_cnt_q;
        if (push) begin
            ent_d[tail_q] = bus.fifo_dout;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d     = ptr_inc(head_q);
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_ok_q   <= 1'b0;
            occ_q      <= 2'd0;
            pend_q     <= 1'b0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            ent_q[0]   <= '0;
            ent_q[1]   <= '0;
            ent_q[2]   <= '0;
            beat_cnt_q <= 32'd0;
        end else begin
            rst_ok_q   <= rst_ok_d;
            occ_q      <= occ_d;
            pend_q     <= pend_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ent_q      <= ent_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = ent_q[head_q];
    assign bus.beat_cnt   = beat_cnt_q;

`ifdef FIFO_DRAIN_LAST_EN
    localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PW-1:0] PKT_MAX = PW'(PKT_LEN - 1);

    logic [PW-1:0] pkt_q, pkt_d;

    always_comb begin
        pkt_d = pkt_q;
        if (pop) pkt_d = (pkt_q == PKT_MAX) ? '0 : pkt_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pkt_q <= '0;
        else        pkt_q <= pkt_d;
    end

    assign bus.m_last = (occ_q != 2'd0) & (pkt_q == PKT_MAX);
`else
    assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain: behavioural FIFO with registered read data feeds the DUT.
module tb_fifo_stream_drain;
    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_drain_if #(.WIDTH(WIDTH)) bus ();

    fifo_stream_drain #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Upstream FIFO model: data appears on fifo_dout the cycle after an accepted read.
    logic [WIDTH-1:0] mem [0:2047];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic empty_ovr = 1'b0;

    assign bus.fifo_empty = ~empty_ovr & (wr_ptr == rd_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= wr_ptr;
            bus.fifo_dout <= '0;
        end else if (bus.fifo_rd_en) begin
            bus.fifo_dout <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int exp_beats = 0;

    task automatic push(input logic [WIDTH-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    function automatic logic [WIDTH-1:0] rval(input int i);
        int t;
        t = i * 37 + 11;
        return t[WIDTH-1:0];
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; bus.en = 1'b1; bus.m_ready = 1'b0; empty_ovr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        n_cmp++; if (bus.beat_cnt !== 32'd0) begin n_err++; $display("FAIL reset_beat_cnt: got %0d want 0", bus.beat_cnt); end
        n_cmp++; if (bus.m_data !== 8'h00) begin n_err++; $display("FAIL reset_m_data: got %h want 00", bus.m_data); end
        n_cmp++; if (bus.m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
        empty_ovr = 1'b0; bus.en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_m_valid: got %b want 0", bus.m_valid); end
        exp_beats = 0;
    endtask

    task automatic test_latency;
        push(8'hA5);
        bus.m_ready = 1'b1;
        @(posedge clk); #1 bus.en = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL lat_rd_en_c0: got %b want 1", bus.fifo_rd_en); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid_c0: got %b want 0", bus.m_valid); end
        @(negedge clk);
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid_c1: got %b want 0", bus.m_valid); end
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL lat_rd_en_c1: got %b want 0", bus.fifo_rd_en); end
        @(negedge clk);
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid_c2: got %b want 1", bus.m_valid); end
        n_cmp++; if (bus.m_data !== 8'hA5) begin n_err++; $display("FAIL lat_data_c2: got %h want a5", bus.m_data); end
        exp_beats = 1;
        @(negedge clk);
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid_c3: got %b want 0", bus.m_valid); end
        n_cmp++; if (bus.beat_cnt !== 32'd1) begin n_err++; $display("FAIL lat_beat_cnt: got %0d want 1", bus.beat_cnt); end
    endtask

    task automatic test_throughput;
        int got = 0, gaps = 0, bad = 0;
        bit started = 0;
        bus.en = 1'b0; bus.m_ready = 1'b1;
        for (int i = 0; i < 100; i++) push(WIDTH'(i));
        @(posedge clk); #1 bus.en = 1'b1;
        for (int c = 0; c < 400 && got < 100; c++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                started = 1;
                if (bus.m_data !== got[WIDTH-1:0]) bad++;
                got++;
            end else if (started) gaps++;
        end
        exp_beats += 100;
        n_cmp++; if (got !== 100) begin n_err++; $display("FAIL tput_count: got %0d want 100", got); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL tput_order: got %0d bad beats want 0", bad); end
        n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL tput_gaps: got %0d idle cycles want 0", gaps); end
        @(negedge clk);
        n_cmp++; if (bus.beat_cnt !== 32'(exp_beats)) begin n_err++; $display("FAIL tput_beat_cnt: got %0d want %0d", bus.beat_cnt, exp_beats); end
    endtask

    task automatic test_backpressure;
        int reads = 0, held_bad = 0, got = 0, gaps = 0, bad = 0;
        bus.en = 1'b0; bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(WIDTH'(8'h10 + i));
        @(posedge clk); #1 bus.en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) reads++;
            if (bus.m_valid && bus.m_data !== 8'h10) held_bad++;
        end
        n_cmp++; if (reads !== 3) begin n_err++; $display("FAIL bp_reads: got %0d want 3", reads); end
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en_stall: got %b want 0", bus.fifo_rd_en); end
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_stall: got %b want 1", bus.m_valid); end
        n_cmp++; if (held_bad !== 0) begin n_err++; $display("FAIL bp_data_held: got %0d unstable cycles want 0", held_bad); end
        @(posedge clk); #1 bus.m_ready = 1'b1;
        for (int c = 0; c < 100 && got < 10; c++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                if (bus.m_data !== WIDTH'(8'h10 + got)) bad++;
                got++;
            end else gaps++;
        end
        exp_beats += 10;
        n_cmp++; if (got !== 10) begin n_err++; $display("FAIL bp_count: got %0d want 10", got); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_order: got %0d bad beats want 0", bad); end
        n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL bp_gaps: got %0d idle cycles want 0", gaps); end
        @(negedge clk);
        n_cmp++; if (bus.beat_cnt !== 32'(exp_beats)) begin n_err++; $display("FAIL bp_beat_cnt: got %0d want %0d", bus.beat_cnt, exp_beats); end
    endtask

    task automatic test_random;
        int pushed = 0, got = 0, bad = 0, viol = 0, cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                push(rval(pushed));
                pushed++;
            end
            bus.m_ready = ($urandom_range(0, 1) == 1);
            bus.en      = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.fifo_rd_en && bus.fifo_empty) viol++;
            if (bus.m_valid && bus.m_ready) begin
                if (bus.m_data !== rval(got)) bad++;
                got++;
            end
            cyc++;
        end
        exp_beats += got;
        n_cmp++; if (got !== 1000) begin n_err++; $display("FAIL rand_count: got %0d want 1000", got); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rand_order: got %0d bad beats want 0", bad); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL rand_rd_when_empty: got %0d cycles want 0", viol); end
        @(negedge clk);
        n_cmp++; if (bus.beat_cnt !== 32'(exp_beats)) begin n_err++; $display("FAIL rand_beat_cnt: got %0d want %0d", bus.beat_cnt, exp_beats); end
    endtask

    task automatic test_reset_midop;
        bus.en = 1'b0; bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(WIDTH'(8'hE0 + i));
        @(posedge clk); #1 bus.en = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus.m_valid); end
        n_cmp++; if (bus.beat_cnt !== 32'd0) begin n_err++; $display("FAIL midrst_beat_cnt: got %0d want 0", bus.beat_cnt); end
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL midrst_rd_en: got %b want 0", bus.fifo_rd_en); end
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale: got %b want 0", bus.m_valid); end
        exp_beats = 0;
    endtask

    task automatic test_last;
        int got = 0, lasts = 0, stray = 0, bad = 0;
        logic exp_last;
        bus.en = 1'b1; bus.m_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(WIDTH'(8'h40 + i));
        for (int c = 0; c < 200 && got < 12; c++) begin
            @(posedge clk); #1 bus.m_ready = ((c % 3) != 1);
            @(negedge clk);
            if (!bus.m_valid && bus.m_last) stray++;
            if (bus.m_valid && bus.m_ready) begin
`ifdef FIFO_DRAIN_LAST_EN
                exp_last = ((got % PKT_LEN) == PKT_LEN - 1);
`else
                exp_last = 1'b0;
`endif
                if (bus.m_data !== WIDTH'(8'h40 + got)) bad++;
                n_cmp++; if (bus.m_last !== exp_last) begin n_err++; $display("FAIL last_beat%0d: got %b want %b", got + 1, bus.m_last, exp_last); end
                if (bus.m_last) lasts++;
                got++;
            end
        end
        n_cmp++; if (got !== 12) begin n_err++; $display("FAIL last_count: got %0d want 12", got); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL last_order: got %0d bad beats want 0", bad); end
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL last_without_valid: got %0d cycles want 0", stray); end
`ifdef FIFO_DRAIN_LAST_EN
        n_cmp++; if (lasts !== 3) begin n_err++; $display("FAIL last_total: got %0d want 3", lasts); end
`else
        n_cmp++; if (lasts !== 0) begin n_err++; $display("FAIL last_total: got %0d want 0", lasts); end
`endif
    endtask

    initial begin
        bus.en = 1'b0;
        bus.m_ready = 1'b0;
        test_reset;
        test_latency;
        test_throughput;
        test_backpressure;
        test_random;
        test_reset_midop;
        test_last;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
